// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffered transmit front-end for MiniUART.
// Bytes arrive on a valid/ready stream and are queued in a small FIFO.
// A bus-master FSM polls the UART line-status register and writes the head
// byte to the DATA register whenever the transmitter reports idle. After
// each write it waits a fixed number of quiet cycles, because the UART's
// "transmitter idle" bit only falls some time after the write lands.
module uart_tx_feeder #(
  parameter int         AW        = 4,
  parameter logic [2:0] ADDR_DATA = 3'd0,
  parameter logic [2:0] ADDR_LSR  = 3'd1,
  parameter int         TS_BIT    = 5,
  parameter int         GUARD_CYC = 4
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW:0]   fifo_count,
  output logic          busy,
  output logic [2:0]    UART_ADD_O,
  output logic [31:0]   UART_DAT_O,
  input  logic [31:0]   UART_DAT_I,
  output logic          UART_STB_O,
  output logic          UART_WE_O
);

  localparam int DEPTH = 2 ** AW;
  localparam int GW    = $clog2(GUARD_CYC) + 1;
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_POLL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_GUARD = 2'd3;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop, full;
  logic [7:0]    head;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [2:0]    add_q, add_d;
  logic [7:0]    dat_q, dat_d;
  logic          ts;

  // Only the transmitter-idle bit of the status word matters here.
  logic          unused_dat;
  assign unused_dat = ^UART_DAT_I;
  assign ts         = UART_DAT_I[TS_BIT];

  // A full FIFO refuses input even when a pop happens in the same cycle.
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state_q == ST_WRITE);
  assign head     = mem_q[rd_ptr_q];

  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE);
  assign UART_STB_O = stb_q;
  assign UART_WE_O  = we_q;
  assign UART_ADD_O = add_q;
  assign UART_DAT_O = {24'b0, dat_q};

  // Pointer and occupancy update; pointers wrap naturally at 2**AW.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge CLK_I) begin
    // NOTE: storage has no reset; emptiness is tracked by the pointers and count alone.
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // Bus-master sequencing: IDLE -> POLL -> WRITE -> GUARD -> POLL/IDLE.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && count_q != '0) state_d = ST_POLL;
      end
      ST_POLL: begin
        if (!enable || count_q == '0) state_d = ST_IDLE;
        else if (ts)                  state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_GUARD;
        guard_d = GUARD_LOAD;
      end
      ST_GUARD: begin
        if (guard_q == '0) state_d = (enable && count_q != '0) ? ST_POLL : ST_IDLE;
        else               guard_d = guard_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs decoded from the next state so they are glitch-free flops.
  always_comb begin
    stb_d = (state_d == ST_POLL) || (state_d == ST_WRITE);
    we_d  = (state_d == ST_WRITE);
    add_d = we_d ? ADDR_DATA : ADDR_LSR;
    dat_d = dat_q;
    if (state_d == ST_WRITE) dat_d = head;
  end

  // Control and bus registers; reset drops the strobe immediately.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      // NOTE: sequential state uses non-blocking assignments only.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      guard_q  <= '0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      add_q    <= ADDR_LSR;
      dat_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      guard_q  <= guard_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      add_q    <= add_d;
      dat_q    <= dat_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: table-driven vectors, directed corner-case
// sequences and a randomized run, all checked against a queue-based model
// of accepted bytes plus the bus-protocol rules of the feeder.
module tb_uart_tx_feeder;

  localparam int AW        = 4;
  localparam int DEPTH     = 16;
  localparam int GUARD_CYC = 4;
  localparam int TS_BIT    = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [AW:0] fifo_count;
  logic        busy;
  logic [2:0]  uart_add;
  logic [31:0] uart_dat_o;
  logic [31:0] uart_dat_i = 32'h0;
  logic        stb;
  logic        we;

  always #5 clk = ~clk;

  uart_tx_feeder dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .enable     (enable),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .fifo_count (fifo_count),
    .busy       (busy),
    .UART_ADD_O (uart_add),
    .UART_DAT_O (uart_dat_o),
    .UART_DAT_I (uart_dat_i),
    .UART_STB_O (stb),
    .UART_WE_O  (we)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: bytes accepted but not yet written, and the write log.
  byte unsigned mq[$];
  byte unsigned wlog[$];
  int           wcyc[$];
  int  cyc       = 0;
  int  last_wr   = -1000;
  bit  prev_poll = 1'b0;
  bit  prev_ts   = 1'b0;
  bit  prev_en   = 1'b0;
  bit  ts_v      = 1'b0;
  int  stb_seen  = 0;
  int  n_accepted = 0;
  int  n_written  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // UART status model: ts on its bit, random noise elsewhere.
  task automatic set_ts(input bit t);
    ts_v = t;
    uart_dat_i = $urandom;
    uart_dat_i[TS_BIT] = t;
  endtask

  task automatic model_clear();
    mq.delete();
    wlog.delete();
    wcyc.delete();
    last_wr   = -1000;
    prev_poll = 1'b0;
    prev_ts   = 1'b0;
    prev_en   = 1'b0;
  endtask

  // One clock cycle: observe the bus, apply protocol rules, update the model.
  task automatic cycle();
    bit wr, poll;
    int sz;
    wr   = stb && we;
    poll = stb && !we;
    if (stb) stb_seen++;
    check("in_ready", in_ready, mq.size() < DEPTH);
    if (stb)  check("busy_when_stb", busy, 1);
    if (poll) check("poll_addr", uart_add, 3'd1);
    if (cyc != last_wr && cyc - last_wr <= GUARD_CYC) check("guard_quiet", stb, 0);
    if (prev_poll) begin
      if (!prev_en)     check("poll_exit_on_disable", stb, 0);
      else if (prev_ts) check("write_after_ts1", wr, 1);
      else              check("keep_polling", poll, 1);
    end
    if (wr) begin
      check("write_addr", uart_add, 3'd0);
      check("write_after_poll_ts1", prev_poll && prev_ts, 1);
      check("write_spacing", (cyc - last_wr) >= GUARD_CYC + 2, 1);
      check("write_has_data", mq.size() != 0, 1);
      if (mq.size() != 0) check("write_data", uart_dat_o, {24'b0, mq[0]});
      wlog.push_back(uart_dat_o[7:0]);
      wcyc.push_back(cyc);
      last_wr = cyc;
      n_written++;
    end
    sz = mq.size();
    if (wr && sz > 0) mq.delete(0);
    if (in_valid && sz < DEPTH) begin
      mq.push_back(in_data);
      n_accepted++;
    end
    prev_poll = poll;
    prev_ts   = ts_v;
    prev_en   = enable;
    @(posedge clk);
    #1;
    cyc++;
    check("fifo_count", fifo_count, mq.size());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    enable   = 1'b0;
    set_ts(1'b0);
    #1;
    check("rst_count", fifo_count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_stb", stb, 0);
    check("rst_we", we, 0);
    check("rst_add", uart_add, 3'd1);
    check("rst_dat", uart_dat_o, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (mq.size() == 0 && !busy && fifo_count == 0) begin
        done = 1'b1;
        break;
      end
      cycle();
    end
    if (mq.size() == 0 && !busy && fifo_count == 0) done = 1'b1;
    check(name, done, 1);
  endtask

  task automatic wait_write(input int budget, input string name);
    for (int i = 0; i < budget && !(stb && we); i++) cycle();
    check(name, stb && we, 1);
  endtask

  typedef struct {
    bit           v;
    byte unsigned d;
    bit           en;
    bit           ts;
    int           cnt;
    bit           rdy;
    bit           stb;
    bit           we;
    bit           busy;
    byte unsigned dat;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];

  initial begin
    // Expected outputs are those seen just after the clock edge that ends
    // the cycle in which the vector's inputs are applied.
    tbl[0]  = '{1'b1, 8'h41, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 8'h5A, 1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h5A};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};

    // Single byte end to end, then a second byte that waits one poll.
    do_reset();
    for (int i = 0; i < NV; i++) begin
      enable   = tbl[i].en;
      in_valid = tbl[i].v;
      in_data  = tbl[i].d;
      set_ts(tbl[i].ts);
      cycle();
      check($sformatf("vec%0d_count", i), fifo_count, tbl[i].cnt);
      check($sformatf("vec%0d_ready", i), in_ready, tbl[i].rdy);
      check($sformatf("vec%0d_stb", i), stb, tbl[i].stb);
      check($sformatf("vec%0d_we", i), we, tbl[i].we);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      if (tbl[i].we) check($sformatf("vec%0d_dat", i), uart_dat_o, {24'b0, tbl[i].dat});
    end
    in_valid = 1'b0;
    run_until_idle(20, "vec_tail_idle");

    // Transmitter busy for 20 cycles: only status reads, then in-order writes.
    do_reset();
    enable = 1'b1;
    set_ts(1'b0);
    push_byte(8'h48);
    push_byte(8'h69);
    for (int i = 0; i < 20; i++) begin
      set_ts(1'b0);
      cycle();
    end
    check("t2_no_write_while_ts0", wlog.size(), 0);
    set_ts(1'b1);
    run_until_idle(60, "t2_drain");
    check("t2_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("t2_first", wlog[0], 8'h48);
      check("t2_second", wlog[1], 8'h69);
      check("t2_gap", wcyc[1] - wcyc[0], GUARD_CYC + 2);
    end

    // Fill past capacity with the drain stopped, then drain everything.
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      if (i == 16) check("t3_full_ready", in_ready, 0);
      cycle();
    end
    in_valid = 1'b0;
    check("t3_count16", fifo_count, 16);
    enable = 1'b1;
    set_ts(1'b1);
    run_until_idle(200, "t3_drain");
    check("t3_nwrites", wlog.size(), 16);
    if (wlog.size() == 16) begin
      for (int i = 0; i < 16; i++) check($sformatf("t3_byte%0d", i), wlog[i], 8'(8'h10 + i));
      for (int i = 1; i < 16; i++) check($sformatf("t3_gap%0d", i), wcyc[i] - wcyc[i-1], GUARD_CYC + 2);
    end

    // Full FIFO with a push offered in the WRITE cycle: rejected, retry accepted.
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'(8'h80 + i));
    enable = 1'b1;
    set_ts(1'b1);
    wait_write(20, "t4_write_seen");
    in_valid = 1'b1;
    in_data  = 8'hEE;
    check("t4_ready_in_write", in_ready, 0);
    cycle();
    check("t4_count15", fifo_count, 15);
    check("t4_ready_after", in_ready, 1);
    cycle();
    check("t4_count16", fifo_count, 16);
    in_valid = 1'b0;
    run_until_idle(300, "t4_drain");
    check("t4_nwrites", wlog.size(), 17);
    if (wlog.size() == 17) begin
      check("t4_first", wlog[0], 8'h80);
      check("t4_last", wlog[16], 8'hEE);
    end

    // Enable dropped during the guard after the first of three bytes.
    do_reset();
    enable = 1'b1;
    set_ts(1'b1);
    push_byte(8'hA1);
    push_byte(8'hA2);
    push_byte(8'hA3);
    wait_write(20, "t5_write_seen");
    cycle();
    enable   = 1'b0;
    stb_seen = 0;
    for (int i = 0; i < 30; i++) cycle();
    check("t5_no_stb", stb_seen, 0);
    check("t5_count2", fifo_count, 2);
    check("t5_one_write", wlog.size(), 1);
    enable = 1'b1;
    run_until_idle(100, "t5_drain");
    check("t5_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("t5_b0", wlog[0], 8'hA1);
      check("t5_b1", wlog[1], 8'hA2);
      check("t5_b2", wlog[2], 8'hA3);
    end

    // Asynchronous reset in the middle of a WRITE cycle.
    do_reset();
    enable = 1'b1;
    set_ts(1'b1);
    push_byte(8'h77);
    wait_write(20, "t6_write_seen");
    #2;
    rst = 1'b1;
    #1;
    check("t6_stb_low", stb, 0);
    check("t6_we_low", we, 0);
    check("t6_count0", fifo_count, 0);
    check("t6_ready", in_ready, 1);
    check("t6_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    stb_seen = 0;
    for (int i = 0; i < 20; i++) cycle();
    check("t6_no_stb_after", stb_seen, 0);
    check("t6_no_write_after", wlog.size(), 0);
    push_byte(8'h78);
    run_until_idle(40, "t6_drain");
    check("t6_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) check("t6_byte", wlog[0], 8'h78);

    // Randomized traffic, enable and transmitter status.
    do_reset();
    n_accepted = 0;
    n_written  = 0;
    for (int i = 0; i < 1500; i++) begin
      in_valid = ($urandom_range(0, 99) < ((i < 750) ? 60 : 12));
      in_data  = 8'($urandom);
      enable   = ($urandom_range(0, 9) != 0);
      set_ts($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    enable   = 1'b1;
    set_ts(1'b1);
    run_until_idle(400, "rand_drain");
    check("rand_all_written", n_written, n_accepted);
    check("rand_final_count", fifo_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
